// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the UART receive path.
package uart_pkg;

    localparam int UART_DATA_BITS = 8;
    localparam logic UART_IDLE = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } uart_state_e;

    function automatic logic maj3(input logic [2:0] v);
        return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for a single asynchronous input pin.
module sync_2ff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic q_o
);

    logic [1:0] ff_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) ff_q <= {2{RST_VAL}};
        else       ff_q <= {ff_q[0], d_i};
    end

    assign q_o = ff_q[1];

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 receiver with majority-voted mid-bit sampling,
// a one-entry valid/ready output buffer and error pulses.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      rxd,
    output logic [UART_DATA_BITS-1:0] rx_data,
    output logic                      rx_valid,
    input  logic                      rx_ready,
    output logic                      busy,
    output logic                      framing_error,
    output logic                      overrun
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(UART_DATA_BITS);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(UART_DATA_BITS - 1);

    uart_state_e               state_q, state_d;
    logic                      rxd_s;
    logic [2:0]                hist_q, hist_d;
    logic [CW-1:0]             cnt_q, cnt_d;
    logic [BW-1:0]             bit_q, bit_d;
    logic [UART_DATA_BITS-1:0] sh_q, sh_d;
    logic                      done_q, done_d;
    logic                      bad_q, bad_d;
    logic [UART_DATA_BITS-1:0] data_q, data_d;
    logic                      valid_q, valid_d;
    logic                      busy_q, busy_d;
    logic                      ferr_q, ferr_d;
    logic                      ovr_q, ovr_d;
    logic                      tick, maj, accept;

    sync_2ff #(.RST_VAL(UART_IDLE)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d_i   (rxd),
        .q_o   (rxd_s)
    );

    assign tick = (cnt_q == '0);
    assign maj  = maj3(hist_q);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (rxd_s != UART_IDLE) state_d = START;
            START:   if (tick) state_d = maj ? IDLE : DATA;
            DATA:    if (tick && bit_q == LAST_BIT) state_d = STOP;
            STOP:    if (tick) state_d = maj ? IDLE : BREAK;
            BREAK:   if (rxd_s == UART_IDLE) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // IDLE keeps the counter preloaded so the first tick lands mid start bit.
    always_comb begin
        hist_d = {hist_q[1:0], rxd_s};
        cnt_d  = tick ? FULL_M1 : cnt_q - 1'b1;
        bit_d  = bit_q;
        sh_d   = sh_q;
        done_d = 1'b0;
        bad_d  = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = HALF_M1;
                bit_d = '0;
            end
            DATA: if (tick) begin
                sh_d  = {maj, sh_q[UART_DATA_BITS-1:1]};
                bit_d = bit_q + 1'b1;
            end
            STOP: if (tick) begin
                done_d = maj;
                bad_d  = ~maj;
            end
            default: ;
        endcase
    end

    // A completing byte and a consumer read in the same cycle swap the buffer contents.
    always_comb begin
        accept  = valid_q & rx_ready;
        valid_d = done_q | (valid_q & ~accept);
        data_d  = (done_q & (~valid_q | accept)) ? sh_q : data_q;
        ovr_d   = done_q & valid_q & ~rx_ready;
        ferr_d  = bad_q;
        busy_d  = (state_q != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hist_q  <= {3{UART_IDLE}};
            cnt_q   <= HALF_M1;
            bit_q   <= '0;
            sh_q    <= '0;
            done_q  <= 1'b0;
            bad_q   <= 1'b0;
            data_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            hist_q  <= hist_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            done_q  <= done_d;
            bad_q   <= bad_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end

    assign rx_data       = data_q;
    assign rx_valid      = valid_q;
    assign busy          = busy_q;
    assign framing_error = ferr_q;
    assign overrun       = ovr_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: scoreboard bench for uart_rx; stimulus queues expected bytes,
// a negedge monitor pops and compares on every handshake.
module tb_uart_rx;

    localparam int N   = 16;
    localparam int LAT = 3 + N / 2 + 9 * N + 1;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rxd = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready = 1'b1;
    logic       busy;
    logic       framing_error;
    logic       overrun;

    int         tests = 0;
    int         fails = 0;
    int         cyc = 0;
    int         rise_cyc = -1;
    int         fe_cnt = 0;
    int         ov_cnt = 0;
    logic       prev_valid = 1'b0;
    logic [7:0] sb[$];

    uart_rx #(.CLKS_PER_BIT(N)) dut (
        .clk           (clk),
        .reset         (reset),
        .rxd           (rxd),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .rx_ready      (rx_ready),
        .busy          (busy),
        .framing_error (framing_error),
        .overrun       (overrun)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (rx_valid && !prev_valid) rise_cyc = cyc;
            prev_valid = rx_valid;
            if (framing_error) fe_cnt++;
            if (overrun) ov_cnt++;
            if (rx_valid && rx_ready) begin
                tests++;
                if (sb.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_byte: got %0h expected none", rx_data);
                end else begin
                    logic [7:0] exp;
                    exp = sb.pop_front();
                    if (rx_data !== exp) begin
                        fails++;
                        $display("FAIL byte: got %0h expected %0h", rx_data, exp);
                    end
                end
            end
        end else begin
            prev_valid = 1'b0;
        end
    end

    // Frame drive starts at posedge+1; ncyc truncates the frame, spike inverts one cycle.
    task automatic send_frame(input logic [7:0] b, input logic stop, input int spike, input int ncyc);
        logic [9:0] fr;
        fr = {stop, b, 1'b0};
        for (int k = 0; k < ncyc; k++) begin
            rxd = fr[k / N] ^ (k == spike);
            @(posedge clk);
            #1;
        end
        rxd = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_drain(input string name, input int max);
        for (int i = 0; i < max && sb.size() != 0; i++) @(posedge clk);
        #1;
        chk(name, sb.size(), 0);
    endtask

    task automatic check_reset(input string tag);
        @(negedge clk);
        chk({tag, "_data"}, rx_data, 0);
        chk({tag, "_valid"}, rx_valid, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_ferr"}, framing_error, 0);
        chk({tag, "_ovr"}, overrun, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t_fall;
        int n;
        check_reset("rst");
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle(4);

        // Clean back-to-back bytes and pin-to-valid latency
        sb.push_back(8'h55);
        sb.push_back(8'hA3);
        t_fall = cyc;
        send_frame(8'h55, 1'b1, -1, 10 * N);
        chk("latency", rise_cyc - t_fall, LAT);
        send_frame(8'hA3, 1'b1, -1, 10 * N);
        wait_drain("drain_clean", 2 * LAT);
        chk("clean_ferr", fe_cnt, 0);
        chk("clean_ovr", ov_cnt, 0);

        // Short glitch must be discarded
        rxd = 1'b0;
        idle(4);
        rxd = 1'b1;
        chk("glitch_busy_hi", busy, 1);
        n = 0;
        while (busy && n < 11) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("glitch_busy_lo", busy, 0);
        idle(2 * N);

        // Single-cycle spike at the middle of bit 3 outvoted
        sb.push_back(8'h00);
        send_frame(8'h00, 1'b1, 4 * N + N / 2, 10 * N);
        wait_drain("drain_maj", 2 * LAT);

        // Bad stop bit followed by a long break
        send_frame(8'hA3, 1'b0, -1, 10 * N);
        rxd = 1'b0;
        idle(40 * N);
        chk("break_busy", busy, 1);
        chk("break_ferr", fe_cnt, 1);
        rxd = 1'b1;
        idle(6);
        chk("break_busy_lo", busy, 0);
        idle(2 * N);

        // Overrun with a held buffer, then same-cycle accept and reload
        rx_ready = 1'b0;
        sb.push_back(8'h11);
        send_frame(8'h11, 1'b1, -1, 10 * N);
        send_frame(8'h22, 1'b1, -1, 10 * N);
        chk("ovr_data", rx_data, 8'h11);
        chk("ovr_valid", rx_valid, 1);
        chk("ovr_cnt", ov_cnt, 1);
        sb.push_back(8'h33);
        fork
            send_frame(8'h33, 1'b1, -1, 10 * N);
            begin
                idle(LAT - 1);
                rx_ready = 1'b1;
            end
        join
        wait_drain("drain_ovr", 2 * LAT);
        chk("ovr_cnt_after", ov_cnt, 1);

        // Reset in the middle of bit 4 of 0xFF
        send_frame(8'hFF, 1'b1, -1, 5 * N + N / 2);
        chk("pre_reset_busy", busy, 1);
        reset = 1'b1;
        rxd = 1'b1;
        check_reset("midrst");
        idle(3);
        reset = 1'b0;
        idle(4);
        sb.push_back(8'h3C);
        send_frame(8'h3C, 1'b1, -1, 10 * N);
        wait_drain("drain_rst", 2 * LAT);
        idle(2 * N);
        chk("final_ferr", fe_cnt, 1);
        chk("final_ovr", ov_cnt, 1);
        chk("final_queue", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
